// File: rtl/vram_arbiter_if.sv
// Bus bundle tying the VGA fetcher, the CPU load/store path and the VRAM port to the arbiter.
interface vram_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8
);
  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_gnt;
  logic              vga_rvalid;
  logic [DATA_W-1:0] vga_rdata;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  // Arbiter side: takes requests and RAM read data, drives grants, responses and the RAM port.
  modport slave (
    input  vga_req, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    output vga_gnt, vga_rvalid, vga_rdata, cpu_gnt, cpu_rvalid, cpu_rdata,
           ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output vga_req, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    input  vga_gnt, vga_rvalid, vga_rdata, cpu_gnt, cpu_rvalid, cpu_rdata,
           ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: VGA scanout has priority, a saturating wait counter bounds CPU starvation.
module vram_arbiter #(
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic           clk,
  input  logic           rst,
  vram_arbiter_if.slave  bus
);
  localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    OWN_IDLE,
    OWN_VGA,
    OWN_CPU_RD,
    OWN_CPU_WR
  } owner_t;

  owner_t            owner, owner_next, rd_owner;
  logic [WAIT_W-1:0] wait_cnt, wait_next;
  logic              vga_gnt, cpu_gnt;
  logic              ram_en_q, ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic              ram_we_next;
  logic [ADDR_W-1:0] ram_addr_next;
  logic [DATA_W-1:0] ram_wdata_next;
  logic              vga_rvalid, cpu_rvalid;
  logic [DATA_W-1:0] vga_rdata_q, cpu_rdata_q;

  always_comb begin
    owner_next     = OWN_IDLE;
    wait_next      = '0;
    ram_we_next    = 1'b0;
    ram_addr_next  = '0;
    ram_wdata_next = '0;

    cpu_gnt = bus.cpu_req & (~bus.vga_req | (wait_cnt >= WAIT_MAX));
    vga_gnt = bus.vga_req & ~cpu_gnt;

    // A refused CPU request ages towards MAX_WAIT, where it overrides VGA priority.
    if (bus.cpu_req && !cpu_gnt) begin
      wait_next = (wait_cnt < WAIT_MAX) ? wait_cnt + 1'b1 : wait_cnt;
    end

    if (vga_gnt) begin
      owner_next    = OWN_VGA;
      ram_addr_next = bus.vga_addr;
    end else if (cpu_gnt) begin
      owner_next    = bus.cpu_we ? OWN_CPU_WR : OWN_CPU_RD;
      ram_we_next   = bus.cpu_we;
      ram_addr_next = bus.cpu_addr;
      if (bus.cpu_we) begin
        ram_wdata_next = bus.cpu_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner       <= OWN_IDLE;
      rd_owner    <= OWN_IDLE;
      wait_cnt    <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      vga_rdata_q <= '0;
      cpu_rdata_q <= '0;
    end else begin
      owner       <= owner_next;
      rd_owner    <= (owner == OWN_CPU_WR) ? OWN_IDLE : owner;
      wait_cnt    <= wait_next;
      ram_en_q    <= (owner_next != OWN_IDLE);
      ram_we_q    <= ram_we_next;
      ram_addr_q  <= ram_addr_next;
      ram_wdata_q <= ram_wdata_next;
      if (vga_rvalid) begin
        vga_rdata_q <= bus.ram_rdata;
      end
      if (cpu_rvalid) begin
        cpu_rdata_q <= bus.ram_rdata;
      end
    end
  end

  // RAM data arrives the cycle after the access; pass it straight through, then hold it.
  assign vga_rvalid     = (rd_owner == OWN_VGA);
  assign cpu_rvalid     = (rd_owner == OWN_CPU_RD);

  assign bus.vga_gnt    = vga_gnt;
  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.vga_rvalid = vga_rvalid;
  assign bus.cpu_rvalid = cpu_rvalid;
  assign bus.vga_rdata  = vga_rvalid ? bus.ram_rdata : vga_rdata_q;
  assign bus.cpu_rdata  = cpu_rvalid ? bus.ram_rdata : cpu_rdata_q;
  assign bus.ram_en     = ram_en_q;
  assign bus.ram_we     = ram_we_q;
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_wdata  = ram_wdata_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed scenarios plus a randomized run against a queue-based model.
module tb_vram_arbiter;
  localparam int ADDR_W   = 15;
  localparam int DATA_W   = 8;
  localparam int MAX_WAIT = 4;

  typedef struct {
    int              due;
    bit              is_vga;
    logic [DATA_W-1:0] data;
  } resp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  vram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // VRAM model, preloaded with a ramp (word at address a holds a[7:0]).
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  initial for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'(i);

  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] = bus.ram_wdata;
      else bus.ram_rdata <= mem[bus.ram_addr];
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic vr, input logic [ADDR_W-1:0] va,
                               input logic cr, input logic cw,
                               input logic [ADDR_W-1:0] ca, input logic [DATA_W-1:0] cd);
    bus.vga_req   = vr;
    bus.vga_addr  = va;
    bus.cpu_req   = cr;
    bus.cpu_we    = cw;
    bus.cpu_addr  = ca;
    bus.cpu_wdata = cd;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    applyStimulus(1'b1, 15'h0010, 1'b1, 1'b0, 15'h0020, 8'h00);
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_ram: got en=%b we=%b addr=%h wdata=%h, want all 0",
               bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata);
    end
    checks++;
    if ({bus.vga_rvalid, bus.cpu_rvalid, bus.vga_rdata, bus.cpu_rdata} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_resp: got vrv=%b crv=%b vrd=%h crd=%h, want all 0",
               bus.vga_rvalid, bus.cpu_rvalid, bus.vga_rdata, bus.cpu_rdata);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.vga_gnt !== 1'b1 || bus.cpu_gnt !== 1'b0 || bus.ram_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_first_gnt: got vg=%b cg=%b en=%b, want 1 0 0",
               bus.vga_gnt, bus.cpu_gnt, bus.ram_en);
    end
    @(negedge clk);
    checks++;
    if (bus.ram_en !== 1'b1 || bus.ram_we !== 1'b0 || bus.ram_addr !== 15'h0010) begin
      errors++;
      $display("[TB] FAIL reset_first_en: got en=%b we=%b addr=%h, want 1 0 0010",
               bus.ram_en, bus.ram_we, bus.ram_addr);
    end
    bus.vga_req = 1'b0;
    #1;
    checks++;
    if (bus.cpu_gnt !== 1'b1 || bus.vga_gnt !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_cpu_gnt: got cg=%b vg=%b, want 1 0", bus.cpu_gnt, bus.vga_gnt);
    end
    @(negedge clk);
    checks++;
    if (bus.vga_rvalid !== 1'b1 || bus.vga_rdata !== 8'h10 || bus.cpu_rvalid !== 1'b0 ||
        bus.ram_addr !== 15'h0020) begin
      errors++;
      $display("[TB] FAIL reset_vga_resp: got vrv=%b vrd=%h crv=%b addr=%h, want 1 10 0 0020",
               bus.vga_rvalid, bus.vga_rdata, bus.cpu_rvalid, bus.ram_addr);
    end
    bus.cpu_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 8'h20 || bus.vga_rvalid !== 1'b0 ||
        bus.ram_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_cpu_resp: got crv=%b crd=%h vrv=%b en=%b, want 1 20 0 0",
               bus.cpu_rvalid, bus.cpu_rdata, bus.vga_rvalid, bus.ram_en);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_store_load();
    @(negedge clk);
    applyStimulus(1'b0, 15'h0, 1'b1, 1'b1, 15'h0123, 8'hE3);
    #1;
    checks++;
    if (bus.cpu_gnt !== 1'b1 || bus.vga_gnt !== 1'b0) begin
      errors++;
      $display("[TB] FAIL store_gnt: got cg=%b vg=%b, want 1 0", bus.cpu_gnt, bus.vga_gnt);
    end
    @(negedge clk);
    checks++;
    if (bus.ram_en !== 1'b1 || bus.ram_we !== 1'b1 || bus.ram_addr !== 15'h0123 ||
        bus.ram_wdata !== 8'hE3) begin
      errors++;
      $display("[TB] FAIL store_ram: got en=%b we=%b addr=%h wdata=%h, want 1 1 0123 e3",
               bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata);
    end
    bus.cpu_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.cpu_rvalid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL store_no_rvalid: got crv=%b, want 0", bus.cpu_rvalid);
    end
    applyStimulus(1'b0, 15'h0, 1'b1, 1'b0, 15'h0123, 8'h00);
    #1;
    checks++;
    if (bus.cpu_gnt !== 1'b1) begin
      errors++;
      $display("[TB] FAIL load_gnt: got cg=%b, want 1", bus.cpu_gnt);
    end
    @(negedge clk);
    bus.cpu_req = 1'b0;
    checks++;
    if (bus.cpu_rvalid !== 1'b0 || bus.ram_we !== 1'b0 || bus.ram_wdata !== 8'h00) begin
      errors++;
      $display("[TB] FAIL load_stage1: got crv=%b we=%b wdata=%h, want 0 0 00",
               bus.cpu_rvalid, bus.ram_we, bus.ram_wdata);
    end
    @(negedge clk);
    checks++;
    if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 8'hE3) begin
      errors++;
      $display("[TB] FAIL load_resp: got crv=%b crd=%h, want 1 e3", bus.cpu_rvalid, bus.cpu_rdata);
    end
    @(negedge clk);
    checks++;
    if (bus.cpu_rvalid !== 1'b0 || bus.cpu_rdata !== 8'hE3) begin
      errors++;
      $display("[TB] FAIL load_hold: got crv=%b crd=%h, want 0 e3", bus.cpu_rvalid, bus.cpu_rdata);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_contention();
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      applyStimulus(1'b1, 15'h0200, 1'b1, 1'b0, 15'h0300, 8'h00);
      #1;
      checks++;
      if (bus.cpu_gnt !== ((i % 5) == 4) || bus.vga_gnt !== ((i % 5) != 4)) begin
        errors++;
        $display("[TB] FAIL contention_c%0d: got cg=%b vg=%b, want cg=%b vg=%b", i,
                 bus.cpu_gnt, bus.vga_gnt, (i % 5) == 4, (i % 5) != 4);
      end
    end
    @(negedge clk);
    applyStimulus(1'b0, 15'h0, 1'b0, 1'b0, 15'h0, 8'h00);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_vga_burst();
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      checks++;
      if (k >= 2 && k < 10) begin
        if (bus.vga_rvalid !== 1'b1 || bus.vga_rdata !== 8'(k - 2)) begin
          errors++;
          $display("[TB] FAIL burst_resp%0d: got vrv=%b vrd=%h, want 1 %h", k,
                   bus.vga_rvalid, bus.vga_rdata, 8'(k - 2));
        end
      end else if (bus.vga_rvalid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL burst_idle%0d: got vrv=%b, want 0", k, bus.vga_rvalid);
      end
      if (k < 8) begin
        applyStimulus(1'b1, 15'(k), 1'b0, 1'b0, 15'h0, 8'h00);
        #1;
        checks++;
        if (bus.vga_gnt !== 1'b1) begin
          errors++;
          $display("[TB] FAIL burst_gnt%0d: got vg=%b, want 1", k, bus.vga_gnt);
        end
      end else begin
        bus.vga_req = 1'b0;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    applyStimulus(1'b0, 15'h0, 1'b1, 1'b0, 15'h0042, 8'h00);
    #1;
    checks++;
    if (bus.cpu_gnt !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midop_gnt: got cg=%b, want 1", bus.cpu_gnt);
    end
    @(negedge clk);
    bus.cpu_req = 1'b0;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (bus.cpu_rvalid !== 1'b0 || bus.vga_rvalid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL midop_discard%0d: got crv=%b vrv=%b, want 0 0", k,
                 bus.cpu_rvalid, bus.vga_rvalid);
      end
      if (k == 1) rst = 1'b1;
    end
    applyStimulus(1'b0, 15'h0, 1'b1, 1'b0, 15'h0042, 8'h00);
    @(negedge clk);
    bus.cpu_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 8'h42) begin
      errors++;
      $display("[TB] FAIL midop_reload: got crv=%b crd=%h, want 1 42", bus.cpu_rvalid, bus.cpu_rdata);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_same_addr();
    @(negedge clk);
    applyStimulus(1'b1, 15'h0050, 1'b1, 1'b1, 15'h0050, 8'hA5);
    #1;
    checks++;
    if (bus.vga_gnt !== 1'b1 || bus.cpu_gnt !== 1'b0) begin
      errors++;
      $display("[TB] FAIL same_gnt0: got vg=%b cg=%b, want 1 0", bus.vga_gnt, bus.cpu_gnt);
    end
    @(negedge clk);
    bus.vga_req = 1'b0;
    #1;
    checks++;
    if (bus.cpu_gnt !== 1'b1) begin
      errors++;
      $display("[TB] FAIL same_gnt1: got cg=%b, want 1", bus.cpu_gnt);
    end
    @(negedge clk);
    checks++;
    if (bus.vga_rvalid !== 1'b1 || bus.vga_rdata !== 8'h50) begin
      errors++;
      $display("[TB] FAIL same_old: got vrv=%b vrd=%h, want 1 50", bus.vga_rvalid, bus.vga_rdata);
    end
    bus.cpu_req = 1'b0;
    bus.vga_req = 1'b1;
    @(negedge clk);
    bus.vga_req = 1'b0;
    checks++;
    if (bus.cpu_rvalid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL same_store_rvalid: got crv=%b, want 0", bus.cpu_rvalid);
    end
    @(negedge clk);
    checks++;
    if (bus.vga_rvalid !== 1'b1 || bus.vga_rdata !== 8'hA5) begin
      errors++;
      $display("[TB] FAIL same_new: got vrv=%b vrd=%h, want 1 a5", bus.vga_rvalid, bus.vga_rdata);
    end
    repeat (2) @(negedge clk);
  endtask

  // Model: requests served one per cycle in grant order, reads see every earlier-granted store.
  task automatic test_random(input int n);
    logic [DATA_W-1:0] shadow [int];
    resp_t             exp_q [$];
    int                wait_m = 0;
    bit                vp = 0, cp = 0, cwe = 0, exp_vg, exp_cg, exp_vv, exp_cv;
    logic [ADDR_W-1:0] vaddr = '0, caddr = '0, exp_addr = '0;
    logic [DATA_W-1:0] cwd = '0, exp_wd = '0, rd;
    bit                exp_en = 0, exp_we = 0;
    for (int k = 0; k < n + 20; k++) begin
      @(negedge clk);
      checks++;
      if (bus.ram_en !== exp_en ||
          (exp_en && (bus.ram_we !== exp_we || bus.ram_addr !== exp_addr || bus.ram_wdata !== exp_wd))) begin
        errors++;
        $display("[TB] FAIL rand_ram@%0d: got en=%b we=%b addr=%h wd=%h, want %b %b %h %h", k,
                 bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata, exp_en, exp_we, exp_addr, exp_wd);
      end
      exp_vv = exp_q.size() > 0 && exp_q[0].due == k && exp_q[0].is_vga;
      exp_cv = exp_q.size() > 0 && exp_q[0].due == k && !exp_q[0].is_vga;
      checks++;
      if (bus.vga_rvalid !== exp_vv || bus.cpu_rvalid !== exp_cv ||
          (exp_vv && bus.vga_rdata !== exp_q[0].data) || (exp_cv && bus.cpu_rdata !== exp_q[0].data)) begin
        errors++;
        $display("[TB] FAIL rand_resp@%0d: got vrv=%b vrd=%h crv=%b crd=%h, want vrv=%b crv=%b data=%h", k,
                 bus.vga_rvalid, bus.vga_rdata, bus.cpu_rvalid, bus.cpu_rdata, exp_vv, exp_cv,
                 exp_q.size() > 0 ? exp_q[0].data : 8'h00);
      end
      if (exp_vv || exp_cv) void'(exp_q.pop_front());
      if (k < n && !vp && $urandom_range(0, 3) != 0) begin
        vp = 1; vaddr = 15'(32'h100 + $urandom_range(0, 7));
      end
      if (k < n && !cp && $urandom_range(0, 1) != 0) begin
        cp = 1; cwe = 1'($urandom_range(0, 1));
        caddr = 15'(32'h100 + $urandom_range(0, 7)); cwd = 8'($urandom);
      end
      applyStimulus(vp, vaddr, cp, cwe, caddr, cwd);
      #1;
      exp_cg = cp && (!vp || wait_m >= MAX_WAIT);
      exp_vg = vp && !exp_cg;
      checks++;
      if (bus.vga_gnt !== exp_vg || bus.cpu_gnt !== exp_cg) begin
        errors++;
        $display("[TB] FAIL rand_gnt@%0d: got vg=%b cg=%b, want %b %b", k,
                 bus.vga_gnt, bus.cpu_gnt, exp_vg, exp_cg);
      end
      wait_m = (cp && !exp_cg) ? ((wait_m < MAX_WAIT) ? wait_m + 1 : MAX_WAIT) : 0;
      exp_en = exp_vg || exp_cg;
      exp_we = 0; exp_wd = '0;
      if (exp_vg) begin
        exp_addr = vaddr;
        rd = shadow.exists(int'(vaddr)) ? shadow[int'(vaddr)] : vaddr[7:0];
        exp_q.push_back('{k + 2, 1'b1, rd});
        vp = 0;
      end else if (exp_cg) begin
        exp_addr = caddr;
        if (cwe) begin
          exp_we = 1; exp_wd = cwd; shadow[int'(caddr)] = cwd;
        end else begin
          rd = shadow.exists(int'(caddr)) ? shadow[int'(caddr)] : caddr[7:0];
          exp_q.push_back('{k + 2, 1'b0, rd});
        end
        cp = 0;
      end
    end
    checks++;
    if (vp || cp || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL rand_drain: got vp=%b cp=%b queued=%0d, want 0 0 0", vp, cp, exp_q.size());
    end
    applyStimulus(1'b0, 15'h0, 1'b0, 1'b0, 15'h0, 8'h00);
  endtask

  initial begin
    applyStimulus(1'b0, 15'h0, 1'b0, 1'b0, 15'h0, 8'h00);
    test_reset();
    test_store_load();
    test_contention();
    test_vga_burst();
    test_reset_midop();
    test_same_addr();
    test_random(400);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
